// File: rtl/cond_logic_pkg.sv
// Shared encodings for the condition unit: ARM condition codes and NZCV bit positions.
package cond_logic_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_logic_cond_check.sv
// Pure combinational evaluation of an ARM condition field against the NZCV flags.
module cond_logic_cond_check
  import cond_logic_pkg::*;
#(
  parameter bit NV_EXECUTES = 1'b0
) (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    condex = 1'b0;
    unique case (cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = (n == v);
      COND_LT: condex = (n != v);
      COND_GT: condex = ~z & (n == v);
      COND_LE: condex = z | (n != v);
      COND_AL: condex = 1'b1;
      COND_NV: condex = NV_EXECUTES;
      default: condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Condition unit: holds NZCV, evaluates the instruction condition and gates decode's write
// requests into architectural write enables for the register file, memory and PC.
module cond_logic
  import cond_logic_pkg::*;
#(
  parameter bit         NV_EXECUTES = 1'b0,
  parameter logic [3:0] FLAGS_RST   = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx
);

  logic       condex_c;
  logic       condex_q;
  logic [1:0] nz_q;
  logic [1:0] cv_q;
  logic [1:0] flag_write;

  assign Flags = {nz_q, cv_q};

  // Evaluated from the registered flags so a same-cycle flag update cannot affect it.
  cond_logic_cond_check #(
    .NV_EXECUTES(NV_EXECUTES)
  ) u_cond_check (
    .cond  (Cond),
    .flags (Flags),
    .condex(condex_c)
  );

  assign flag_write = FlagW & {2{condex_c}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nz_q <= FLAGS_RST[FLAG_N:FLAG_Z];
    end else if (flag_write[1]) begin
      nz_q <= ALUFlags[FLAG_N:FLAG_Z];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cv_q <= FLAGS_RST[FLAG_C:FLAG_V];
    end else if (flag_write[0]) begin
      cv_q <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      condex_q <= 1'b0;
    end else begin
      condex_q <= condex_c;
    end
  end

  // condex_q clears asynchronously, so reset alone suppresses RegWrite/MemWrite.
  assign CondEx   = condex_q;
  assign RegWrite = RegW & condex_q;
  assign MemWrite = MemW & condex_q;
  assign PCWrite  = (PCS & condex_q) | NextPC;

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic: vector table, reset/override sequences and a full
// condition x flags sweep against an independent golden model for both NV settings.
module tb_cond_logic;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, NextPC, RegW, MemW;

  logic       pcw0, rw0, mw0, cx0;
  logic [3:0] fl0;
  logic       pcw1, rw1, mw1, cx1;
  logic [3:0] fl1;

  int checks = 0;
  int errors = 0;

  cond_logic #(
    .NV_EXECUTES(1'b0),
    .FLAGS_RST  (4'b0000)
  ) dut0 (
    .clk     (clk),
    .reset   (reset),
    .Cond    (Cond),
    .ALUFlags(ALUFlags),
    .FlagW   (FlagW),
    .PCS     (PCS),
    .NextPC  (NextPC),
    .RegW    (RegW),
    .MemW    (MemW),
    .PCWrite (pcw0),
    .RegWrite(rw0),
    .MemWrite(mw0),
    .Flags   (fl0),
    .CondEx  (cx0)
  );

  cond_logic #(
    .NV_EXECUTES(1'b1),
    .FLAGS_RST  (4'b1010)
  ) dut1 (
    .clk     (clk),
    .reset   (reset),
    .Cond    (Cond),
    .ALUFlags(ALUFlags),
    .FlagW   (FlagW),
    .PCS     (PCS),
    .NextPC  (NextPC),
    .RegW    (RegW),
    .MemW    (MemW),
    .PCWrite (pcw1),
    .RegWrite(rw1),
    .MemWrite(mw1),
    .Flags   (fl1),
    .CondEx  (cx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cond;
    logic [1:0] flagw;
    logic [3:0] alu;
    logic       regw, memw, pcs, nextpc;
    logic [3:0] e_flags;
    logic       e_condex, e_regwrite, e_memwrite, e_pcwrite;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] a,
                       input logic rw, input logic mw, input logic pc, input logic np);
    Cond = c; FlagW = fw; ALUFlags = a; RegW = rw; MemW = mw; PCS = pc; NextPC = np;
  endtask

  // Grouped by cond[3:1]; odd codes are the complement of the even one, except NV.
  function automatic logic golden(input logic [3:0] c, input logic [3:0] f, input logic nv);
    logic n, z, cc, v, base;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cc;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cc & ~z;
      3'd5:    base = ~(n ^ v);
      3'd6:    base = ~z & ~(n ^ v);
      default: return c[0] ? nv : 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  initial begin
    //            cond     fw     alu      rw mw pc np  flags    cx rw mw pc
    vecs[0]  = '{4'b1110, 2'b11, 4'b0100, 1, 0, 0, 0, 4'b0100, 1, 1, 0, 0};
    vecs[1]  = '{4'b0000, 2'b00, 4'b1111, 1, 1, 1, 0, 4'b0100, 1, 1, 1, 1};
    vecs[2]  = '{4'b0001, 2'b00, 4'b1111, 1, 1, 1, 0, 4'b0100, 0, 0, 0, 0};
    vecs[3]  = '{4'b0001, 2'b11, 4'b1111, 1, 0, 0, 0, 4'b0100, 0, 0, 0, 0};
    vecs[4]  = '{4'b1110, 2'b10, 4'b1010, 0, 0, 0, 0, 4'b1000, 1, 0, 0, 0};
    vecs[5]  = '{4'b1011, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b1000, 1, 1, 0, 0};
    vecs[6]  = '{4'b1010, 2'b00, 4'b0000, 1, 0, 1, 1, 4'b1000, 0, 0, 0, 1};
    vecs[7]  = '{4'b1010, 2'b00, 4'b0000, 0, 0, 1, 0, 4'b1000, 0, 0, 0, 0};
    vecs[8]  = '{4'b1110, 2'b01, 4'b0011, 0, 1, 0, 0, 4'b1011, 1, 0, 1, 0};
    vecs[9]  = '{4'b1000, 2'b00, 4'b0000, 0, 0, 1, 0, 4'b1011, 1, 0, 0, 1};
    vecs[10] = '{4'b1100, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b1011, 1, 1, 0, 0};
    vecs[11] = '{4'b1101, 2'b00, 4'b0000, 1, 1, 1, 0, 4'b1011, 0, 0, 0, 0};
    vecs[12] = '{4'b1110, 2'b11, 4'b0000, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0};
    vecs[13] = '{4'b0000, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0};
    vecs[14] = '{4'b1111, 2'b11, 4'b1111, 1, 1, 1, 0, 4'b0000, 0, 0, 0, 0};

    reset = 1'b0;
    drive(4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_flags0", fl0, 4'b0000);
    chk("rst_flags1", fl1, 4'b1010);
    chk("rst_condex", {3'b0, cx0}, 4'b0000);
    @(negedge clk);
    reset = 1'b1;

    // Each vector: inputs held across one rising edge, outputs checked on the falling edge.
    foreach (vecs[i]) begin
      drive(vecs[i].cond, vecs[i].flagw, vecs[i].alu, vecs[i].regw, vecs[i].memw,
            vecs[i].pcs, vecs[i].nextpc);
      @(negedge clk);
      chk($sformatf("v%0d_flags", i), fl0, vecs[i].e_flags);
      chk($sformatf("v%0d_condex", i), {3'b0, cx0}, {3'b0, vecs[i].e_condex});
      chk($sformatf("v%0d_regwrite", i), {3'b0, rw0}, {3'b0, vecs[i].e_regwrite});
      chk($sformatf("v%0d_memwrite", i), {3'b0, mw0}, {3'b0, vecs[i].e_memwrite});
      chk($sformatf("v%0d_pcwrite", i), {3'b0, pcw0}, {3'b0, vecs[i].e_pcwrite});
    end

    // Combinational outputs follow request inputs without a clock edge.
    drive(4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0);
    @(negedge clk);
    RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
    #1;
    chk("comb_regwrite", {3'b0, rw0}, 4'b0001);
    chk("comb_memwrite", {3'b0, mw0}, 4'b0001);
    chk("comb_pcwrite", {3'b0, pcw0}, 4'b0001);

    // Asynchronous reset mid-cycle with flags 1111 and a pending write.
    drive(4'b1110, 2'b11, 4'b1111, 1, 1, 0, 0);
    @(negedge clk);
    chk("pre_rst_flags", fl0, 4'b1111);
    chk("pre_rst_regwrite", {3'b0, rw0}, 4'b0001);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_flags0", fl0, 4'b0000);
    chk("async_rst_flags1", fl1, 4'b1010);
    chk("async_rst_condex", {3'b0, cx0}, 4'b0000);
    chk("async_rst_regwrite", {3'b0, rw0}, 4'b0000);
    chk("async_rst_memwrite", {3'b0, mw0}, 4'b0000);
    NextPC = 1'b1; PCS = 1'b1;
    #1;
    chk("rst_pcwrite_np1", {3'b0, pcw0}, 4'b0001);
    NextPC = 1'b0;
    #1;
    chk("rst_pcwrite_np0", {3'b0, pcw0}, 4'b0000);
    @(negedge clk);
    chk("rst_hold_flags", fl0, 4'b0000);
    reset = 1'b1;

    // Full sweep: load flags through AL, then evaluate each condition.
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        drive(4'b1110, 2'b11, 4'(f), 0, 0, 0, 0);
        @(negedge clk);
        drive(4'(c), 2'b00, 4'b0000, 0, 0, 0, 0);
        @(negedge clk);
        chk($sformatf("sweep_nv0_c%0d_f%0d", c, f), {3'b0, cx0},
            {3'b0, golden(4'(c), 4'(f), 1'b0)});
        chk($sformatf("sweep_nv1_c%0d_f%0d", c, f), {3'b0, cx1},
            {3'b0, golden(4'(c), 4'(f), 1'b1)});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
